// File: rtl/irq_pkg.sv
// Shared types and helpers for the set/reset interrupt bank.
package irq_pkg;

  // Handshake phases: no request, request presented, mandatory one-cycle drop.
  typedef enum logic [1:0] {
    Idle = 2'd0,
    Req  = 2'd1,
    Gap  = 2'd2
  } state_e;

  // Width of the channel index; never narrower than one bit.
  function automatic int unsigned idw(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset flag bit. A set event always survives an acknowledge-clear;
// against a software clear the winner is chosen by SET_WINS.
module sr_cell #(
  parameter bit SET_WINS = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_evt,
  input  logic clr,
  input  logic ack_clr,
  output logic flag
);

  logic flag_q, flag_d;

  // Next flag value: set (subject to clr priority), else clear, else hold.
  always_comb begin
    flag_d = flag_q;
    if (set_evt && (SET_WINS || !clr)) begin
      flag_d = 1'b1;
    end else if (clr || ack_clr) begin
      flag_d = 1'b0;
    end
  end

  // Flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/sr_irq_bank.sv
// Bank of set/reset interrupt flags with a lowest-index-first request/ack
// handshake. irq and id come straight from registers.
module sr_irq_bank
  import irq_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned SET_WINS = 1,
  parameter int unsigned EDGE     = 0,
  localparam int unsigned IDW     = idw(CH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  set,
  input  logic [CH-1:0]  clr,
  input  logic [CH-1:0]  mask,
  input  logic           ack,
  output logic [CH-1:0]  flags,
  output logic           irq,
  output logic [IDW-1:0] id
);

  logic [CH-1:0]  set_q;
  logic [CH-1:0]  armed_q;
  logic [CH-1:0]  set_evt;
  logic [CH-1:0]  id_sel;
  logic [CH-1:0]  ack_clr;
  logic [CH-1:0]  flags_q;
  logic [CH-1:0]  pend;
  logic [IDW-1:0] low_idx;
  logic           cur_flag;
  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic           irq_q;

  // Edge tracking. armed_q marks channels whose set input has been seen low
  // (including at the reset edge), so a level held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_q   <= '0;
      armed_q <= ~set;
    end else begin
      set_q   <= set;
      armed_q <= armed_q | ~set;
    end
  end

  assign set_evt = (EDGE != 0) ? (set & ~set_q & armed_q) : set;

  // Decode the presented id; ack only clears the presented channel in Req.
  always_comb begin
    id_sel = '0;
    for (int i = 0; i < int'(CH); i++) begin
      id_sel[i] = (id_q == IDW'(i));
    end
    ack_clr  = id_sel & {CH{ack && (state_q == Req)}};
    cur_flag = |(flags_q & id_sel);
  end

  for (genvar g = 0; g < int'(CH); g++) begin : gen_cell
    sr_cell #(
      .SET_WINS (SET_WINS != 0)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .set_evt (set_evt[g]),
      .clr     (clr[g]),
      .ack_clr (ack_clr[g]),
      .flag    (flags_q[g])
    );
  end

  // Lowest enabled pending channel.
  always_comb begin
    pend    = flags_q & mask;
    low_idx = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        low_idx = IDW'(i);
      end
    end
  end

  // Handshake next-state; mask is only consulted when choosing a new request.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      Idle: begin
        if (|pend) begin
          id_d    = low_idx;
          state_d = Req;
        end
      end
      Req: begin
        if (ack || !cur_flag) begin
          state_d = Gap;
        end
      end
      Gap:     state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // Handshake registers; irq is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Idle;
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= (state_d == Req);
    end
  end

  assign flags = flags_q;
  assign irq   = irq_q;
  assign id    = id_q;

endmodule

// File: tb/tb_sr_irq_bank.sv
// Bench for sr_irq_bank: directed vector table, hand sequences for the
// SET_WINS=0 and EDGE=1 builds, then random stimulus against a behavioural model.
module tb_sr_irq_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [3:0] set, clr, mask;

  logic [3:0] flags_a, flags_b, flags_c;
  logic       irq_a, irq_b, irq_c;
  logic [1:0] id_a, id_b, id_c;

  always #5 clk = ~clk;

  sr_irq_bank #(.CH(4), .SET_WINS(1), .EDGE(0)) dut_a (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .mask(mask), .ack(ack),
    .flags(flags_a), .irq(irq_a), .id(id_a)
  );
  sr_irq_bank #(.CH(4), .SET_WINS(0), .EDGE(0)) dut_b (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .mask(mask), .ack(ack),
    .flags(flags_b), .irq(irq_b), .id(id_b)
  );
  sr_irq_bank #(.CH(4), .SET_WINS(1), .EDGE(1)) dut_c (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .mask(mask), .ack(ack),
    .flags(flags_c), .irq(irq_c), .id(id_c)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model, one slot per build: 0=a, 1=b (clr wins), 2=c (edge).
  int         sw_of [3] = '{1, 0, 1};
  int         ed_of [3] = '{0, 0, 1};
  logic [3:0] m_flags [3];
  logic [3:0] m_prev  [3];
  logic [3:0] m_seen  [3];
  int         m_phase [3];  // 0 idle, 1 requesting, 2 gap
  int         m_id    [3];
  int         m_irq   [3];

  task automatic model_edge();
    logic [3:0] ev, ackv, nf, p;
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        m_flags[c] = '0; m_prev[c] = '0; m_seen[c] = ~set;
        m_phase[c] = 0;  m_id[c] = 0;   m_irq[c] = 0;
      end else begin
        ev   = (ed_of[c] != 0) ? (set & ~m_prev[c] & m_seen[c]) : set;
        ackv = (m_phase[c] == 1 && ack) ? (4'b0001 << m_id[c]) : 4'b0000;
        // Surviving old flags plus new sets; clr only blocks a set when clr wins.
        nf   = (m_flags[c] & ~(clr | ackv)) | (ev & ((sw_of[c] != 0) ? 4'hf : ~clr));
        p    = m_flags[c] & mask;
        case (m_phase[c])
          0: if (p != 0) begin
               for (int i = 3; i >= 0; i--) if (p[i]) m_id[c] = i;
               m_phase[c] = 1;
             end
          1: if (ack || !m_flags[c][m_id[c]]) m_phase[c] = 2;
          default: m_phase[c] = 0;
        endcase
        m_irq[c]   = (m_phase[c] == 1) ? 1 : 0;
        m_flags[c] = nf;
        m_prev[c]  = set;
        m_seen[c]  = m_seen[c] | ~set;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [3:0] dflags(input int c);
    return (c == 0) ? flags_a : (c == 1) ? flags_b : flags_c;
  endfunction
  function automatic logic dirq(input int c);
    return (c == 0) ? irq_a : (c == 1) ? irq_b : irq_c;
  endfunction
  function automatic logic [1:0] did(input int c);
    return (c == 0) ? id_a : (c == 1) ? id_b : id_c;
  endfunction

  typedef struct {
    logic       rst;
    logic [3:0] set, clr, mask;
    logic       ack;
    logic [3:0] eflags;
    logic       eirq;
    logic [1:0] eid;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [3:0] c,
                              input logic [3:0] m, input logic a, input logic [3:0] ef,
                              input logic ei, input logic [1:0] eid);
    vec_t v;
    v.rst = r; v.set = s; v.clr = c; v.mask = m; v.ack = a;
    v.eflags = ef; v.eirq = ei; v.eid = eid;
    return v;
  endfunction

  vec_t tbl [33];
  int   set_count;

  initial begin
    rst = 1'b1; ack = 1'b0; set = '0; clr = '0; mask = '0;

    //            rst set    clr    mask   ack  flags  irq id
    tbl[0]  = mk(1, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 0);  // reset state
    tbl[1]  = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 0);
    tbl[2]  = mk(0, 4'h4, 4'h0, 4'hf, 0, 4'h4, 0, 0);  // set ch2 pulse
    tbl[3]  = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h4, 1, 2);  // irq two cycles after set
    tbl[4]  = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h4, 1, 2);
    tbl[5]  = mk(0, 4'h0, 4'h0, 4'hf, 1, 4'h0, 0, 2);  // ack -> gap
    tbl[6]  = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 2);
    tbl[7]  = mk(0, 4'ha, 4'h0, 4'hf, 0, 4'ha, 0, 2);  // set ch1 and ch3
    tbl[8]  = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'ha, 1, 1);  // lowest first
    tbl[9]  = mk(0, 4'h0, 4'h0, 4'hf, 1, 4'h8, 0, 1);
    tbl[10] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h8, 0, 1);
    tbl[11] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h8, 1, 3);
    tbl[12] = mk(0, 4'h0, 4'h0, 4'hf, 1, 4'h0, 0, 3);
    tbl[13] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 3);
    tbl[14] = mk(0, 4'h1, 4'h1, 4'hf, 0, 4'h1, 0, 3);  // set beats clr
    tbl[15] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h1, 1, 0);
    tbl[16] = mk(0, 4'h1, 4'h0, 4'hf, 1, 4'h1, 0, 0);  // ack/set collision
    tbl[17] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h1, 0, 0);
    tbl[18] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h1, 1, 0);  // re-request id 0
    tbl[19] = mk(0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 1, 0);  // unmask keeps request
    tbl[20] = mk(1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0);
    tbl[21] = mk(0, 4'h1, 4'h0, 4'h0, 0, 4'h1, 0, 0);  // masked flag, no irq
    tbl[22] = mk(0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0, 0);
    tbl[23] = mk(0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0, 0);
    tbl[24] = mk(0, 4'h0, 4'h1, 4'h0, 0, 4'h0, 0, 0);
    tbl[25] = mk(0, 4'h2, 4'h0, 4'hf, 0, 4'h2, 0, 0);
    tbl[26] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h2, 1, 1);
    tbl[27] = mk(0, 4'h0, 4'h2, 4'hf, 0, 4'h0, 1, 1);  // clr presented flag
    tbl[28] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 1);  // gap without ack
    tbl[29] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 1);
    tbl[30] = mk(0, 4'h8, 4'h0, 4'hf, 0, 4'h8, 0, 1);
    tbl[31] = mk(0, 4'h0, 4'h0, 4'hf, 0, 4'h8, 1, 3);
    tbl[32] = mk(1, 4'h0, 4'h0, 4'hf, 0, 4'h0, 0, 0);  // reset mid-request

    for (int k = 0; k < 33; k++) begin
      rst = tbl[k].rst; set = tbl[k].set; clr = tbl[k].clr;
      mask = tbl[k].mask; ack = tbl[k].ack;
      step();
      chk($sformatf("tbl%0d flags", k), flags_a, tbl[k].eflags);
      chk($sformatf("tbl%0d irq", k), irq_a, tbl[k].eirq);
      chk($sformatf("tbl%0d id", k), id_a, tbl[k].eid);
    end

    // Same-cycle set and clr on each build.
    rst = 1'b1; set = '0; clr = '0; ack = 1'b0; mask = 4'hf;
    step();
    rst = 1'b0; set = 4'h1; clr = 4'h1;
    step();
    chk("setclr set_wins1", flags_a, 4'h1);
    chk("setclr set_wins0", flags_b, 4'h0);
    chk("setclr edge", flags_c, 4'h1);

    // Edge build: level held through reset must not fire until seen low.
    rst = 1'b1; set = 4'h8; clr = '0;
    step();
    chk("edge rst flags", flags_c, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("edge held%0d flags", k), flags_c, 4'h0);
      chk($sformatf("edge held%0d irq", k), irq_c, 1'b0);
    end
    set = 4'h0;
    step();
    chk("edge low flags", flags_c, 4'h0);
    set = 4'h8;
    set_count = 0;
    for (int k = 0; k < 5; k++) begin
      ack = (k == 3);
      step();
      if (flags_c[3]) set_count++;
      if (k == 1) begin
        chk("edge irq", irq_c, 1'b1);
        chk("edge id", id_c, 2'd3);
      end
    end
    ack = 1'b0;
    chk("edge one fire", set_count, 3);  // flag high from set until ack
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("edge after ack%0d flags", k), flags_c, 4'h0);
      chk($sformatf("edge after ack%0d irq", k), irq_c, 1'b0);
    end

    // Random stimulus against the model on all three builds.
    rst = 1'b1; set = '0; clr = '0; ack = 1'b0; mask = 4'hf;
    step();
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 63) == 0);
      set  = 4'($urandom & $urandom);
      clr  = 4'($urandom & $urandom & $urandom);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      ack  = $urandom_range(0, 1) == 1;
      step();
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("rnd%0d b%0d flags", k, c), dflags(c), m_flags[c]);
        chk($sformatf("rnd%0d b%0d irq", k, c), dirq(c), m_irq[c]);
        chk($sformatf("rnd%0d b%0d id", k, c), did(c), m_id[c]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sr_irq_bank.md
SR_IRQ_BANK -- requirements
Module: sr_irq_bank

Interface
REQ-001 Parameter CH, default 4, number of set/reset flag channels; legal range 1..16.
REQ-002 Parameter SET_WINS, default 1; 1 = set beats clr on the same channel in the same cycle, 0 = clr beats set.
REQ-003 Parameter EDGE, default 0; 0 = set is level-sensitive, 1 = set fires only on a 0->1 transition of set[i].
REQ-004 Derived constant IDW = max(1, clog2(CH)).
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port set, input, CH bits: per-channel set request.
REQ-008 Port clr, input, CH bits: per-channel software clear.
REQ-009 Port mask, input, CH bits: per-channel interrupt enable (1 = enabled); flags still set while masked.
REQ-010 Port ack, input, 1 bit: acknowledge of the currently presented request.
REQ-011 Port flags, output, CH bits: registered flag state.
REQ-012 Port irq, output, 1 bit: interrupt request.
REQ-013 Port id, output, IDW bits: index of the channel being requested.

Function
REQ-014 Set event: set[i] when EDGE=0; set[i] & ~set_q[i] when EDGE=1, where set_q is the previous-cycle sample of set.
- A set event at cycle n shall make flags[i] = 1 at n+1.
REQ-015 When set event and clr[i] coincide on a channel, the outcome shall follow SET_WINS.
- Otherwise the flag holds its value.
REQ-016 The handshake FSM shall have exactly three states:
- IDLE: irq = 0.
- REQ: irq = 1, id stable.
- GAP: irq = 0, one-cycle mandatory drop.
REQ-017 In IDLE, if (flags & mask) != 0, the FSM shall latch id = lowest set index of (flags & mask) and enter REQ next cycle.
REQ-018 Latency: a set event at cycle n on an enabled channel with the FSM idle shall give irq = 1 at n+2.
REQ-019 In REQ with ack = 1, flags[id] shall clear at the next edge and the FSM shall enter GAP; GAP shall always return to IDLE.
REQ-020 Ack/set collision: if a set event on channel id coincides with ack, flags[id] shall remain 1 (event not lost).
- This holds regardless of SET_WINS.
REQ-021 If flags[id] is cleared by clr while in REQ, the FSM shall go to GAP without ack.
REQ-022 Clearing mask[id] while in REQ shall not withdraw the request.
REQ-023 ack shall be ignored in IDLE and GAP; id shall hold its last value outside REQ.
REQ-024 irq and id shall be driven directly from registers (no combinational path from inputs).

Reset
REQ-025 While rst = 1 at a clock edge, the block shall load: flags = 0, set_q = 0, state = IDLE, irq = 0, id = 0.
REQ-026 rst asserted mid-handshake shall abandon the request: irq = 0 the cycle after the reset edge, with no pending flag retained.
REQ-027 With EDGE=1, a set input already high when rst deasserts shall not fire until it has been seen low.

Structure
REQ-028 The shared package irq_pkg shall hold the FSM state enum (IDLE, REQ, GAP) and the IDW derivation function.
REQ-029 The per-channel flag logic shall be one sub-module, sr_cell, instantiated CH times.
- Inputs: set event, clear, ack-clear.
- Parameter: SET_WINS.
- Output: 1 registered bit.

Verification
REQ-030 The bench shall cover at least the following directed scenarios:
- CH=4, mask=4'b1111, set=4'b0100 pulsed at cycle 10 -> flags=4'b0100 at 11, irq=1 and id=2 at 12.
- set=4'b1010 together, mask=4'b1111 -> id=1 first; ack -> GAP, then id=3; after second ack, flags=0 and irq=0.
- SET_WINS=1 with set[0]=clr[0]=1 -> flags[0]=1; rebuilt with SET_WINS=0, same stimulus -> flags[0]=0.
- EDGE=1, set[3] held high for 5 cycles -> exactly one flag set; after ack, flag stays 0 while set[3] remains high.
- In REQ id=0, ack and a new set[0] in the same cycle -> GAP, then REQ with id=0 again.
- rst during REQ -> irq=0, flags=0, id=0 next cycle; mask=0 with flags=4'b0001 -> irq stays 0.
